// File: rtl/ascon_fsm_aead.sv
// -----------------------------------------------------------------------------
// ascon_fsm_aead
//
// Control sequencer for an ASCON-128 authenticated encryption. It steps the
// permutation datapath through initialization (p12), N_AD associated-data
// blocks (p6 each), N_PT plaintext blocks (p6 each) and finalization (p12),
// one permutation round per clock. Data blocks are taken from an upstream
// source with a valid/ready handshake; the first round of every block runs in
// the handshake cycle itself.
//
// Parameters
//   N_AD                number of associated-data blocks (1..15)
//   N_PT                number of plaintext blocks (1..15)
//
// Ports
//   clock_i             clock, rising edge
//   reset_i             asynchronous active-high reset, forces IDLE
//   start_i             start request, sampled only in IDLE
//   data_valid_i        upstream holds a valid AD/PT block
//   data_ready_o        a block can be consumed this cycle
//   round_o             round index for the constant addition (0..11)
//   en_perm_o           state register loads the permutation output
//   sel_perm_o          0: permutation input is IV||K||N, 1: state feedback
//   en_xor_data_o       XOR the data block into the rate before the round
//   en_xor_key_begin_o  XOR 0||K into the state before the round
//   en_xor_key_end_o    XOR the key into the lower 128 bits after the round
//   en_xor_lsb_o        XOR the domain-separation bit after the round
//   en_cipher_o         ciphertext register captures the rate
//   en_tag_o            tag register captures the final lower 128 bits
//   busy_o              high in every state except IDLE
//   end_o               one-cycle pulse when the tag is valid
// -----------------------------------------------------------------------------
module ascon_fsm_aead #(
  parameter int unsigned N_AD = 1,
  parameter int unsigned N_PT = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic [3:0] round_o,
  output logic       en_perm_o,
  output logic       sel_perm_o,
  output logic       en_xor_data_o,
  output logic       en_xor_key_begin_o,
  output logic       en_xor_key_end_o,
  output logic       en_xor_lsb_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       busy_o,
  output logic       end_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_WAIT_AD = 3'd2,
    S_AD      = 3'd3,
    S_WAIT_PT = 3'd4,
    S_PT      = 3'd5,
    S_FIN     = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic [3:0] ROUND_FIRST = 4'd0;
  localparam logic [3:0] ROUND_P6    = 4'd6;  // first round of a p6 block
  localparam logic [3:0] ROUND_LAST  = 4'd11;

  // Block counts saturated into the legal 1..15 range so the 4-bit down
  // counter can never start at zero or wrap.
  localparam logic [3:0] N_AD_C = (N_AD < 1) ? 4'd1 : (N_AD > 15) ? 4'd15 : 4'(N_AD);
  localparam logic [3:0] N_PT_C = (N_PT < 1) ? 4'd1 : (N_PT > 15) ? 4'd15 : 4'(N_PT);

  // ---------------------------------------------------------------------------
  // State, counters and registered (Moore) output flags
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] blk_q,   blk_d;

  logic ready_q,   ready_d;
  logic perm_q,    perm_d;
  logic sel_q,     sel_d;
  logic key_end_q, key_end_d;
  logic lsb_q,     lsb_d;
  logic tag_q,     tag_d;
  logic end_q,     end_d;
  logic busy_q,    busy_d;
  logic pt_wait_q, pt_wait_d;  // waiting for a PT block
  logic pt_last_q, pt_last_d;  // the next PT handshake is the final block

  logic hs;                    // handshake in a WAIT state

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    blk_d   = blk_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_INIT;
          round_d = ROUND_FIRST;
        end
      end

      S_INIT: begin
        if (round_q == ROUND_LAST) begin
          state_d = S_WAIT_AD;
          round_d = ROUND_P6;
          blk_d   = N_AD_C;
        end else begin
          round_d = round_q + 4'd1;
        end
      end

      S_WAIT_AD: begin
        // Round 6 of the block executes in the handshake cycle.
        if (data_valid_i) begin
          state_d = S_AD;
          round_d = ROUND_P6 + 4'd1;
          blk_d   = blk_q - 4'd1;
        end
      end

      S_AD: begin
        if (round_q == ROUND_LAST) begin
          round_d = ROUND_P6;
          if (blk_q == 4'd0) begin
            state_d = S_WAIT_PT;
            blk_d   = N_PT_C;
          end else begin
            state_d = S_WAIT_AD;
          end
        end else begin
          round_d = round_q + 4'd1;
        end
      end

      S_WAIT_PT: begin
        if (data_valid_i) begin
          blk_d = blk_q - 4'd1;
          if (blk_q == 4'd1) begin
            // Last PT block: round 0 of finalization runs in this cycle.
            state_d = S_FIN;
            round_d = ROUND_FIRST + 4'd1;
          end else begin
            state_d = S_PT;
            round_d = ROUND_P6 + 4'd1;
          end
        end
      end

      S_PT: begin
        if (round_q == ROUND_LAST) begin
          state_d = S_WAIT_PT;
          round_d = ROUND_P6;
        end else begin
          round_d = round_q + 4'd1;
        end
      end

      S_FIN: begin
        if (round_q == ROUND_LAST) begin
          state_d = S_DONE;
          round_d = ROUND_FIRST;
        end else begin
          round_d = round_q + 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        round_d = ROUND_FIRST;
      end

      default: begin
        state_d = S_IDLE;
        round_d = ROUND_FIRST;
        blk_d   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore flags decoded from the next state, so once registered they line up
  // with state_q/round_q in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    ready_d   = (state_d == S_WAIT_AD) || (state_d == S_WAIT_PT);
    perm_d    = (state_d == S_INIT) || (state_d == S_AD) ||
                (state_d == S_PT)   || (state_d == S_FIN);
    // Only the very first INIT round reads the freshly loaded IV||K||N.
    sel_d     = perm_d && !((state_d == S_INIT) && (round_d == ROUND_FIRST));
    key_end_d = ((state_d == S_INIT) || (state_d == S_FIN)) && (round_d == ROUND_LAST);
    lsb_d     = (state_d == S_AD) && (round_d == ROUND_LAST) && (blk_d == 4'd0);
    tag_d     = (state_d == S_FIN) && (round_d == ROUND_LAST);
    end_d     = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);
    pt_wait_d = (state_d == S_WAIT_PT);
    pt_last_d = (state_d == S_WAIT_PT) && (blk_d == 4'd1);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      round_q   <= 4'd0;
      blk_q     <= 4'd0;
      ready_q   <= 1'b0;
      perm_q    <= 1'b0;
      sel_q     <= 1'b0;
      key_end_q <= 1'b0;
      lsb_q     <= 1'b0;
      tag_q     <= 1'b0;
      end_q     <= 1'b0;
      busy_q    <= 1'b0;
      pt_wait_q <= 1'b0;
      pt_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      blk_q     <= blk_d;
      ready_q   <= ready_d;
      perm_q    <= perm_d;
      sel_q     <= sel_d;
      key_end_q <= key_end_d;
      lsb_q     <= lsb_d;
      tag_q     <= tag_d;
      end_q     <= end_d;
      busy_q    <= busy_d;
      pt_wait_q <= pt_wait_d;
      pt_last_q <= pt_last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The WAIT states are Mealy: a handshake runs the block's first
  // round in the same cycle, so those enables follow data_valid_i directly.
  // During a stall round_q holds the p6 start value.
  // ---------------------------------------------------------------------------
  assign hs = ready_q & data_valid_i;

  assign data_ready_o       = ready_q;
  assign en_perm_o          = perm_q | hs;
  assign sel_perm_o         = sel_q | hs;
  assign en_xor_data_o      = hs;
  assign en_cipher_o        = hs & pt_wait_q;
  assign en_xor_key_begin_o = hs & pt_last_q;
  assign en_xor_key_end_o   = key_end_q;
  assign en_xor_lsb_o       = lsb_q;
  assign en_tag_o           = tag_q;
  assign busy_o             = busy_q;
  assign end_o              = end_q;
  assign round_o            = (hs & pt_last_q) ? ROUND_FIRST : round_q;

endmodule

// File: tb/tb_ascon_fsm_aead.sv
// -----------------------------------------------------------------------------
// tb_ascon_fsm_aead
//
// Three sequencers run side by side: default parameters (1 AD, 4 PT), the
// minimal 1/1 configuration and a 3/2 configuration. A planner describes each
// encryption as a list of permutation rounds and stall cycles and turns it into
// per-cycle stimulus plus the expected control word. The driver applies one
// step per cycle and queues its expectation; the monitor pops and compares on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_ascon_fsm_aead;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic [2:0]  start_s, valid_s;
  logic [2:0]  ready_w, perm_w, sel_w, xdata_w, kbeg_w, kend_w;
  logic [2:0]  lsb_w, cipher_w, tag_w, busy_w, end_w;
  logic [11:0] round_w;

  ascon_fsm_aead u_dut_def (
    .clock_i(clk), .reset_i(reset_i), .start_i(start_s[0]), .data_valid_i(valid_s[0]),
    .data_ready_o(ready_w[0]), .round_o(round_w[3:0]), .en_perm_o(perm_w[0]),
    .sel_perm_o(sel_w[0]), .en_xor_data_o(xdata_w[0]), .en_xor_key_begin_o(kbeg_w[0]),
    .en_xor_key_end_o(kend_w[0]), .en_xor_lsb_o(lsb_w[0]), .en_cipher_o(cipher_w[0]),
    .en_tag_o(tag_w[0]), .busy_o(busy_w[0]), .end_o(end_w[0])
  );

  ascon_fsm_aead #(.N_AD(1), .N_PT(1)) u_dut_min (
    .clock_i(clk), .reset_i(reset_i), .start_i(start_s[1]), .data_valid_i(valid_s[1]),
    .data_ready_o(ready_w[1]), .round_o(round_w[7:4]), .en_perm_o(perm_w[1]),
    .sel_perm_o(sel_w[1]), .en_xor_data_o(xdata_w[1]), .en_xor_key_begin_o(kbeg_w[1]),
    .en_xor_key_end_o(kend_w[1]), .en_xor_lsb_o(lsb_w[1]), .en_cipher_o(cipher_w[1]),
    .en_tag_o(tag_w[1]), .busy_o(busy_w[1]), .end_o(end_w[1])
  );

  ascon_fsm_aead #(.N_AD(3), .N_PT(2)) u_dut_mix (
    .clock_i(clk), .reset_i(reset_i), .start_i(start_s[2]), .data_valid_i(valid_s[2]),
    .data_ready_o(ready_w[2]), .round_o(round_w[11:8]), .en_perm_o(perm_w[2]),
    .sel_perm_o(sel_w[2]), .en_xor_data_o(xdata_w[2]), .en_xor_key_begin_o(kbeg_w[2]),
    .en_xor_key_end_o(kend_w[2]), .en_xor_lsb_o(lsb_w[2]), .en_cipher_o(cipher_w[2]),
    .en_tag_o(tag_w[2]), .busy_o(busy_w[2]), .end_o(end_w[2])
  );

  // Control word as seen on the outputs of one instance.
  typedef struct packed {
    logic       ready;
    logic       perm;
    logic       sel;
    logic       xdata;
    logic       kbeg;
    logic       kend;
    logic       lsb;
    logic       cipher;
    logic       tag;
    logic       busy;
    logic       done;
    logic [3:0] round;
  } out_t;

  typedef struct {
    int   inst;
    logic start;
    logic valid;
    logic rst;
    logic chk_round;
    out_t exp;
  } step_t;

  step_t plan_q[$];
  step_t sb_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    runs_seen   = 0;

  // ---------------------------------------------------------------------------
  // Reference model helpers
  // ---------------------------------------------------------------------------
  function automatic int nad_of(int inst);
    case (inst)
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int npt_of(int inst);
    case (inst)
      1:       return 1;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic int stall_len(int max_stall);
    if (max_stall <= 0) return 0;
    return int'($urandom_range(32'(max_stall), 0));
  endfunction

  // One permutation round on the control outputs.
  function automatic out_t rnd(int r, logic sel);
    out_t o;
    o       = '0;
    o.busy  = 1'b1;
    o.perm  = 1'b1;
    o.sel   = sel;
    o.round = 4'(r);
    return o;
  endfunction

  task automatic add(int inst, logic start, logic valid, logic rst, logic chk_round, out_t exp);
    step_t s;
    s.inst      = inst;
    s.start     = start;
    s.valid     = valid;
    s.rst       = rst;
    s.chk_round = chk_round;
    s.exp       = exp;
    plan_q.push_back(s);
  endtask

  task automatic plan_idle(int inst, int n);
    for (int i = 0; i < n; i++) add(inst, 1'b0, rbit(), 1'b0, 1'b1, '0);
  endtask

  // Upstream stall: ready high, nothing else, round not specified.
  task automatic plan_stall(int inst, int n, bit hold_start);
    out_t o;
    o       = '0;
    o.ready = 1'b1;
    o.busy  = 1'b1;
    for (int i = 0; i < n; i++) add(inst, hold_start ? 1'b1 : rbit(), 1'b0, 1'b0, 1'b0, o);
  endtask

  // Full encryption: IDLE start cycle, p12, AD blocks, PT blocks, p12, DONE.
  // pt_stall_blk forces a 5-cycle stall before that PT block; rst_round
  // asserts reset during that round of the first AD block and ends the run.
  task automatic plan_run(int inst, int max_stall, int pt_stall_blk, bit hold_start, int rst_round);
    int   n_ad;
    int   n_pt;
    out_t o;
    n_ad = nad_of(inst);
    n_pt = npt_of(inst);
    add(inst, 1'b1, rbit(), 1'b0, 1'b1, '0);
    for (int r = 0; r < 12; r++) begin
      o      = rnd(r, r != 0);
      o.kend = (r == 11);
      add(inst, hold_start ? 1'b1 : rbit(), rbit(), 1'b0, 1'b1, o);
    end
    for (int b = 0; b < n_ad; b++) begin
      plan_stall(inst, stall_len(max_stall), hold_start);
      o       = rnd(6, 1'b1);
      o.ready = 1'b1;
      o.xdata = 1'b1;
      add(inst, hold_start ? 1'b1 : rbit(), 1'b1, 1'b0, 1'b1, o);
      for (int r = 7; r < 12; r++) begin
        if (b == 0 && r == rst_round) begin
          add(inst, rbit(), rbit(), 1'b1, 1'b1, '0);
          return;
        end
        o     = rnd(r, 1'b1);
        o.lsb = (r == 11) && (b == n_ad - 1);
        add(inst, hold_start ? 1'b1 : rbit(), rbit(), 1'b0, 1'b1, o);
      end
    end
    for (int b = 0; b < n_pt; b++) begin
      plan_stall(inst, (b == pt_stall_blk) ? 5 : stall_len(max_stall), hold_start);
      if (b < n_pt - 1) begin
        o        = rnd(6, 1'b1);
        o.ready  = 1'b1;
        o.xdata  = 1'b1;
        o.cipher = 1'b1;
        add(inst, hold_start ? 1'b1 : rbit(), 1'b1, 1'b0, 1'b1, o);
        for (int r = 7; r < 12; r++)
          add(inst, hold_start ? 1'b1 : rbit(), rbit(), 1'b0, 1'b1, rnd(r, 1'b1));
      end else begin
        // Last block: ciphertext capture, key XOR and round 0 of finalization.
        o        = rnd(0, 1'b1);
        o.ready  = 1'b1;
        o.xdata  = 1'b1;
        o.cipher = 1'b1;
        o.kbeg   = 1'b1;
        add(inst, hold_start ? 1'b1 : rbit(), 1'b1, 1'b0, 1'b1, o);
      end
    end
    for (int r = 1; r < 12; r++) begin
      o      = rnd(r, 1'b1);
      o.kend = (r == 11);
      o.tag  = (r == 11);
      add(inst, hold_start ? 1'b1 : rbit(), rbit(), 1'b0, 1'b1, o);
    end
    o      = '0;
    o.busy = 1'b1;
    o.done = 1'b1;
    add(inst, hold_start ? 1'b1 : rbit(), rbit(), 1'b0, 1'b0, o);
  endtask

  function automatic out_t observe(int i);
    out_t o;
    o.ready  = ready_w[i];
    o.perm   = perm_w[i];
    o.sel    = sel_w[i];
    o.xdata  = xdata_w[i];
    o.kbeg   = kbeg_w[i];
    o.kend   = kend_w[i];
    o.lsb    = lsb_w[i];
    o.cipher = cipher_w[i];
    o.tag    = tag_w[i];
    o.busy   = busy_w[i];
    o.done   = end_w[i];
    o.round  = round_w[i*4 +: 4];
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one plan step per cycle, applied just after the rising edge.
  // ---------------------------------------------------------------------------
  initial begin
    reset_i = 1'b1;
    start_s = '0;
    valid_s = '0;

    add(0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    add(0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    plan_idle(0, 3);
    plan_run(0, 0, -1, 1'b0, -1);                          // no stall: end_o at E+49
    plan_idle(0, 2);
    plan_run(0, 0, 1, 1'b0, -1);                           // 5-cycle PT stall: E+54
    plan_idle(0, 1);
    plan_run(0, 0, -1, 1'b0, int'($urandom_range(11, 7))); // reset during AD
    plan_idle(0, 2);
    plan_run(0, 0, -1, 1'b0, -1);
    plan_idle(0, 1);
    plan_run(0, 0, -1, 1'b1, -1);                          // start held high,
    plan_run(0, 0, -1, 1'b1, -1);                          // back-to-back
    plan_idle(1, 2);
    plan_run(1, 0, -1, 1'b0, -1);                          // 1/1: end_o at E+31
    plan_run(1, 2, -1, 1'b1, -1);
    plan_idle(2, 2);
    plan_run(2, 0, -1, 1'b0, -1);
    plan_run(2, 3, -1, 1'b0, -1);
    for (int k = 0; k < 8; k++) begin
      int inst;
      inst = int'($urandom_range(2, 0));
      plan_idle(inst, int'($urandom_range(2, 0)));
      plan_run(inst, int'($urandom_range(3, 0)), -1, rbit(), -1);
    end
    plan_idle(0, 2);

    while (plan_q.size() > 0) begin
      step_t s;
      @(posedge clk);
      #1;
      s = plan_q.pop_front();
      reset_i = s.rst;
      for (int i = 0; i < 3; i++) begin
        start_s[i] = (i == s.inst) ? s.start : 1'b0;
        valid_s[i] = (i == s.inst) ? s.valid : rbit();
      end
      sb_q.push_back(s);
    end

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    if (sb_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // ---------------------------------------------------------------------------
  // Monitor: compare on the falling edge, away from the active edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      step_t       e;
      logic [14:0] got;
      logic [14:0] want;
      logic [14:0] mask;
      e    = sb_q.pop_front();
      got  = observe(e.inst);
      want = e.exp;
      mask = e.chk_round ? 15'h7FFF : 15'h7FF0;
      vectors++;
      if ((got & mask) !== (want & mask)) begin
        miscompares++;
        $display("FAIL ctrl inst%0d vec %0d: got rdy/perm/sel/xd/kb/ke/lsb/ci/tag/busy/end/round=%b want %b",
                 e.inst, vectors, got & mask, want & mask);
      end
      if (e.exp.done) begin
        runs_seen++;
        $display("run %0d done on inst%0d at vector %0d", runs_seen, e.inst, vectors);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ascon_fsm_aead.md
# ascon_fsm_aead

Control FSM that sequences the ASCON-128 permutation datapath through a complete authenticated encryption: initialization (p12), associated data (p6 per block), plaintext (p6 per block), and finalization (p12). Each permutation round takes one clock cycle. The block drives the round counter, state-source select, XOR enables and capture enables of the datapath, and accepts 64-bit data blocks from an upstream source through a valid/ready handshake. It sits next to the permutation in the ASCON top level.

## Interface

Parameters:
- N_AD, 1: number of associated-data blocks. Legal range 1..15.
- N_PT, 4: number of plaintext blocks. Legal range 1..15.

Ports:
- clock_i, input, 1: clock. All state changes on its rising edge.
- reset_i, input, 1: asynchronous reset, active-high. Forces IDLE and clears all registers.
- start_i, input, 1: start request. Sampled only in IDLE.
- data_valid_i, input, 1: upstream holds a valid AD or PT block.
- data_ready_o, output, 1: FSM can consume a block this cycle.
- round_o, output, 4: round index for the permutation constant addition (0..11).
- en_perm_o, output, 1: state register loads the permutation output this cycle.
- sel_perm_o, output, 1: 0 = permutation input is the initial state (IV‖K‖N); 1 = input is state feedback.
- en_xor_data_o, output, 1: XOR the data block into the rate before the round.
- en_xor_key_begin_o, output, 1: XOR 0‖K into the state before the round.
- en_xor_key_end_o, output, 1: XOR the key after the round (lower 128 bits).
- en_xor_lsb_o, output, 1: XOR the domain-separation bit (state LSB) after the round.
- en_cipher_o, output, 1: ciphertext register captures the rate after the data XOR.
- en_tag_o, output, 1: tag register captures the final lower 128 bits.
- busy_o, output, 1: high in every state except IDLE.
- end_o, output, 1: one-cycle pulse when the tag is valid.

## Operation

- States: IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FIN, DONE.
- Round counter: 4-bit. The p12 phases run rounds 0..11. The p6 phases run rounds 6..11.
- Block counter: 4-bit down-counter. It is loaded with N_AD on entry to WAIT_AD and with N_PT on entry to WAIT_PT, and decremented on each handshake.
- IDLE:
  - All outputs are 0.
  - If start_i=1, go to INIT with round=0.
- INIT:
  - en_perm_o=1 every cycle.
  - sel_perm_o=0 at round 0, and 1 otherwise.
  - At round 11, en_xor_key_end_o=1. Then go to WAIT_AD.
- WAIT_AD and WAIT_PT (Mealy outputs):
  - data_ready_o=1.
  - If data_valid_i=0: no enables asserted, state held.
  - If data_valid_i=1 (handshake): that same cycle executes the block's first round, with en_perm_o=1, sel_perm_o=1 and en_xor_data_o=1.
- AD handshake:
  - Round 6 executes in the handshake cycle; go to AD with round 7.
  - AD runs rounds 7..11 with en_perm_o=1 and sel_perm_o=1.
  - At round 11 of the last AD block (counter reaches 0), en_xor_lsb_o=1 and the next state is WAIT_PT. Otherwise the next state is WAIT_AD.
- PT handshake:
  - en_cipher_o=1 in the handshake cycle.
  - If the block is not the last: round 6 executes and the FSM goes to PT (rounds 7..11, then back to WAIT_PT).
  - If the block is the last: en_xor_key_begin_o=1, round 0 executes, and the FSM goes to FIN with round 1.
- FIN:
  - Rounds 1..11 with en_perm_o=1.
  - At round 11, en_xor_key_end_o=1 and en_tag_o=1. Then go to DONE.
- DONE: end_o=1 for one cycle, then return to IDLE.
- start_i is ignored outside IDLE.
- data_valid_i is ignored outside the WAIT states; data_ready_o is 0 there.
- Back-to-back operation: the cycle after DONE is IDLE, so a new start_i is accepted in that IDLE cycle.

## Timing

- Reset values: every output is 0, state is IDLE, both counters are 0.
- Reset asserted mid-operation: the FSM returns to IDLE immediately (asynchronous). Every output reads 0 on the following clock edge and stays 0 until a new start_i.
- start_i=1 sampled at edge E: INIT round 0 occupies cycle E+1, and INIT occupies E+1..E+12. WAIT_AD is first entered at E+13.
- Latency with zero upstream stall, from start edge to end_o: 12 + 6·N_AD + 6·(N_PT−1) + 12 + 1 cycles. With default parameters this is 12+6+18+12+1 = 49, so end_o is high in cycle E+49.
- Each upstream stall cycle in a WAIT state adds exactly one cycle of latency.
- en_xor_lsb_o and en_xor_key_end_o are asserted only on round-11 cycles.
- en_xor_key_begin_o is asserted only in the handshake cycle of the last PT block.

## Test plan

- Reset, then start at E with data_valid_i held at 1 and defaults:
  - end_o pulses exactly at E+49.
  - en_perm_o is high for 48 cycles.
  - data_ready_o handshakes occur at E+13, E+19, E+25, E+31 and E+37.
- Round sequence check:
  - round_o reads 0..11 during INIT.
  - round_o reads 6..11 during each AD/PT block.
  - round_o reads 0..11 during FIN.
  - en_xor_lsb_o is high exactly once (E+18).
  - en_tag_o is high exactly once (E+48).
- Upstream stall: hold data_valid_i=0 for 5 cycles at WAIT_PT → all enables stay 0 and round_o is stable during the stall; end_o moves to E+54.
- N_AD=1, N_PT=1:
  - The single PT handshake (E+19) asserts en_cipher_o, en_xor_key_begin_o and en_xor_data_o together, with round_o=0.
  - end_o pulses at E+31.
- reset_i pulse during AD rounds → every output reads 0 at the next clock edge. A subsequent start_i gives the full 49-cycle run.
- start_i held high throughout → it is ignored while busy. A new run starts from the IDLE cycle following DONE.
